// File: rtl/complex_pkg.sv
// Shared types and defaults for the complex I/Q interleaver.
package complex_pkg;

    // Serializer phase: which half of the current pair goes out next.
    typedef enum logic {
        PH_REAL = 1'b0,
        PH_IMAG = 1'b1
    } phase_t;

    localparam int DEFAULT_DW    = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Width of an occupancy counter able to hold the value DEPTH itself.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding whole {re, im} pairs.
// Full/empty come from a registered occupancy count, so pointer equality
// never has to disambiguate the two. Pointers wrap naturally (DEPTH is a
// power of two). Read data is the current head entry, so a pop can use the
// word in the same cycle it is removed.
module pair_fifo
    import complex_pkg::*;
#(
    parameter int W     = 2 * DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full_o    = (count_q == LW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are ignored rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Next pointer and occupancy values; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards any stored pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/complex_interleaver.sv
// Turns buffered (re, im) pairs into a single-word stream: real word, then
// imag word on the very next cycle with last_o set. A pair is popped only
// when the serializer is about to emit its real half, so a pair can never be
// split by the FIFO running empty. Output words are registered.
module complex_interleaver
    import complex_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW-1:0]           re_i,
    input  logic [DW-1:0]           im_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [DW-1:0]           data_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    logic [2*DW-1:0] wr_data;
    logic [2*DW-1:0] rd_data;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;

    phase_t          phase_q, phase_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [DW-1:0]   imag_q,  imag_d;
    logic            valid_q, valid_d;
    logic            last_q,  last_d;

    // Real half in the upper bits, imag half in the lower bits.
    assign wr_data   = {re_i, im_i};
    // Readiness is purely count based: a pop in progress does not free a slot early.
    assign ready_o   = !fifo_full;
    assign fifo_push = valid_i && ready_o;
    assign fifo_pop  = (phase_q == PH_REAL) && !fifo_empty;

    pair_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fifo_push),
        .wr_data_i (wr_data),
        .pop_i     (fifo_pop),
        .rd_data_o (rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level_o)
    );

    // Serializer next state: emit real and stash imag, then emit imag unconditionally.
    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        imag_d  = imag_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        case (phase_q)
            PH_REAL: begin
                if (!fifo_empty) begin
                    data_d  = rd_data[2*DW-1:DW];
                    imag_d  = rd_data[DW-1:0];
                    valid_d = 1'b1;
                    phase_d = PH_IMAG;
                end
            end
            PH_IMAG: begin
                data_d  = imag_q;
                valid_d = 1'b1;
                last_d  = 1'b1;
                phase_d = PH_REAL;
            end
            default: begin
                phase_d = PH_REAL;
            end
        endcase
    end

    // Phase, held imag word and output registers; reset drops any half-sent pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_REAL;
            data_q  <= '0;
            imag_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
            imag_q  <= imag_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_complex_interleaver.sv
// Self-checking bench for complex_interleaver. The reference model is simply
// the ordered list of words the stream must contain (real then imag of every
// accepted pair) plus the pair count arithmetic for occupancy.
module tb_complex_interleaver;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] re_i;
    logic [DW-1:0] im_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic [2:0]    level_o;

    complex_interleaver #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .re_i    (re_i),
        .im_i    (im_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .level_o (level_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vec_cnt++;
        if (obs !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference model: expected words {last, data} in stream order.
    logic [DW:0] exp_q[$];
    int acc_cnt  = 0;   // pairs accepted since reset
    int real_cnt = 0;   // real words seen on the output since reset
    int cyc      = 0;
    int word_cnt = 0;
    int first_cyc = -1;
    int last_cyc  = -1;

    // Every accepted pair contributes its real then imag word to the expected stream.
    always @(posedge clk) begin
        if (rst_n && valid_i && ready_o) begin
            exp_q.push_back({1'b0, re_i});
            exp_q.push_back({1'b1, im_i});
            acc_cnt++;
        end
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        logic [DW:0] w;
        cyc++;
        if (rst_n) begin
            check_val("last_without_valid", {31'd0, last_o & ~valid_o}, 32'd0);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check_val("word", {15'd0, last_o, data_o}, {15'd0, w});
                    if (!w[DW]) real_cnt++;
                    word_cnt++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
            check_val("level", {29'd0, level_o}, acc_cnt - real_cnt);
            check_val("ready", {31'd0, ready_o}, {31'd0, (acc_cnt - real_cnt) != DEPTH});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check_val("drain_timeout", exp_q.size(), 32'd0);
        tick();
        tick();
    endtask

    // One pair into an idle interleaver, with exact cycle latency checks.
    task automatic send_single(input logic [DW-1:0] re, input logic [DW-1:0] im);
        re_i    = re;
        im_i    = im;
        valid_i = 1'b1;
        check_val("single_ready", {31'd0, ready_o}, 32'd1);
        tick();
        valid_i = 1'b0;
        check_val("lat0_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check_val("lat1_valid", {31'd0, valid_o}, 32'd1);
        check_val("lat1_last", {31'd0, last_o}, 32'd0);
        check_val("lat1_data", {16'd0, data_o}, {16'd0, re});
        tick();
        check_val("lat2_valid", {31'd0, valid_o}, 32'd1);
        check_val("lat2_last", {31'd0, last_o}, 32'd1);
        check_val("lat2_data", {16'd0, data_o}, {16'd0, im});
        tick();
        check_val("lat3_valid", {31'd0, valid_o}, 32'd0);
        check_val("lat3_last", {31'd0, last_o}, 32'd0);
        check_val("lat3_hold", {16'd0, data_o}, {16'd0, im});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int guard;
        int max_lvl;
        bit acc;
        bit saw_not_ready;
        int p_re;
        int p_im;

        re_i    = '0;
        im_i    = '0;
        valid_i = 1'b0;
        rst_n   = 1'b0;

        // Reset state
        #3;
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_last", {31'd0, last_o}, 32'd0);
        check_val("rst_data", {16'd0, data_o}, 32'd0);
        check_val("rst_level", {29'd0, level_o}, 32'd0);
        check_val("rst_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single pair with latency
        send_single(16'h1234, 16'hFEDC);
        drain();

        // Extreme values pass bit-exact
        send_single(16'h8000, 16'h7FFF);
        drain();

        // Burst of 8 pairs offered every cycle
        word_cnt      = 0;
        first_cyc     = -1;
        last_cyc      = -1;
        max_lvl       = 0;
        saw_not_ready = 1'b0;
        n             = 1;
        guard         = 0;
        while (n <= 8 && guard < 100) begin
            re_i    = 16'(n);
            im_i    = 16'(-n);
            valid_i = 1'b1;
            acc     = ready_o;
            if (!ready_o) saw_not_ready = 1'b1;
            tick();
            if (acc) n++;
            if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
            guard++;
        end
        valid_i = 1'b0;
        check_val("burst_accept_timeout", n, 32'd9);
        check_val("burst_max_level", max_lvl, DEPTH);
        check_val("burst_saw_backpressure", {31'd0, saw_not_ready}, 32'd1);
        drain();
        check_val("burst_words", word_cnt, 32'd16);
        check_val("burst_gapless_span", last_cyc - first_cyc + 1, 32'd16);

        // Random valid patterns, scoreboard checked by the monitor
        for (int i = 0; i < 100; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            re_i    = 16'($urandom);
            im_i    = 16'($urandom);
            tick();
        end
        valid_i = 1'b0;
        drain();

        // Reset between the real and imag words of a pair
        re_i    = 16'hAAAA;
        im_i    = 16'hBBBB;
        valid_i = 1'b1;
        tick();
        re_i    = 16'hCCCC;
        im_i    = 16'hDDDD;
        tick();
        valid_i = 1'b0;
        check_val("midrst_real", {15'd0, last_o, data_o}, {15'd0, 1'b0, 16'hAAAA});
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_cnt  = 0;
        real_cnt = 0;
        #1;
        check_val("midrst_valid", {31'd0, valid_o}, 32'd0);
        check_val("midrst_last", {31'd0, last_o}, 32'd0);
        check_val("midrst_data", {16'd0, data_o}, 32'd0);
        check_val("midrst_level", {29'd0, level_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        send_single(16'h0001, 16'h0002);
        drain();

        // Feeding the power stage: |3 + 4j|^2 = 25
        re_i    = 16'd3;
        im_i    = 16'd4;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        p_re = int'($signed(data_o));
        tick();
        p_im = int'($signed(data_o));
        check_val("power", p_re * p_re + p_im * p_im, 32'd25);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
